mips_fetch_unit: RTL and testbench

//   Decoupled IF stage for the 5-stage MIPS core. Generates sequential PCs and

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/mips_fetch_unit.sv | 129 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue: synchronous FIFO with flush, registered head and no bypass.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot being written, so push is accepted even when full.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk_i) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled IF stage: PC generation, credit-limited imem requests, in-order queue to IF/ID.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

    fetch_state_t r_state, w_state_next;
    logic          r_run;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_outstanding_next;
    logic [SW-1:0] w_inflight;
    logic          w_xfer;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wentry;

    assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
    // r_run keeps the request low for the first cycle out of reset.
    assign imem_req_o  = r_run && (r_state == FETCH) && (w_inflight < DEPTH_W);
    assign imem_addr_o = r_fetch_pc;
    assign w_xfer      = imem_req_o && imem_gnt_i;
    assign w_outstanding_next = r_outstanding + CW'(w_xfer) - CW'(imem_rvalid_i);
    assign w_wentry    = '{pc: r_resp_pc, instr: imem_rdata_i};

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = inst_valid_o && !stall_i && !redirect_i;
        unique case (r_state)
            FETCH: begin
                w_push = imem_rvalid_i && !redirect_i;
                // outstanding doubles as the drop counter while draining.
                if (redirect_i && (w_outstanding_next != '0)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_outstanding_next == '0) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_outstanding_next;
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i;
                r_resp_pc  <= redirect_pc_i;
            end else begin
                if (w_xfer) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign inst_valid_o = !w_empty;
    assign inst_o       = inst_valid_o ? w_head.instr : NOP_INSTR;
    assign pc_o         = inst_valid_o ? w_head.pc : '0;
    assign pc4_o        = inst_valid_o ? (w_head.pc + PC_STEP) : '0;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: in-order memory model plus expected-stream reference.
module tb_mips_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;

    mips_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int unsigned rdy;
    } pend_t;

    pend_t       pend[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned last_rdy = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned stale_left = 0;
    int unsigned n_consumed = 0;
    int unsigned n_rvalid = 0;
    int          first_xfer = -1;
    int          first_valid = -1;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] prev_addr = '0;
    logic [31:0] first_pc = '0;
    bit          prev_wait = 0;
    bit          chk_reset = 0;
    bit          chk_flush = 0;
    bit          want_first = 0;
    bit          saw_wrap = 0;
    bit          triple_hit = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive memory side, check at negedge, update models, settle after posedge.
    task automatic step();
        int unsigned r;
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        imem_rvalid_i = rst_ni && (pend.size() > 0) && (pend[0].rdy <= cyc);
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0].addr) : $urandom();
        @(negedge clk_i);
        if (!rst_ni) begin
            pend.delete();
            stale_left = 0;
            exp_pc     = RESET_PC;
            exp_req    = RESET_PC;
            chk_reset  = 1;
            chk_flush  = 0;
            prev_wait  = 0;
            last_rdy   = cyc;
        end else begin
            if (chk_reset) begin
                chk("rst_req", {31'b0, imem_req_o}, 32'h0);
                chk("rst_addr", imem_addr_o, RESET_PC);
                chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
                chk_reset = 0;
            end
            if (chk_flush) begin
                chk("valid_after_redirect", {31'b0, inst_valid_o}, 32'h0);
                chk_flush = 0;
            end
            if (!inst_valid_o) begin
                chk("idle_inst", inst_o, 32'h0);
                chk("idle_pc", pc_o, 32'h0);
                chk("idle_pc4", pc4_o, 32'h0);
            end else if (first_valid < 0) begin
                first_valid = int'(cyc);
            end
            if (prev_wait) begin
                chk("req_hold", {31'b0, imem_req_o}, 32'h1);
                chk("addr_hold", imem_addr_o, prev_addr);
            end
            if (stale_left > 0) chk("no_req_while_drain", {31'b0, imem_req_o}, 32'h0);
            if (imem_req_o) chk("addr_align", {30'b0, imem_addr_o[1:0]}, 32'h0);
            if (inst_valid_o && !stall_i && !redirect_i) begin
                chk("stream_pc", pc_o, exp_pc);
                chk("stream_inst", inst_o, mem_word(exp_pc));
                chk("stream_pc4", pc4_o, exp_pc + 32'd4);
                if (want_first) begin
                    first_pc   = pc_o;
                    want_first = 0;
                end
                if (exp_pc == 32'hFFFF_FFFC) saw_wrap = 1;
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (redirect_i && imem_req_o && imem_gnt_i && imem_rvalid_i) triple_hit = 1;
            if (imem_req_o && imem_gnt_i) begin
                chk("req_addr", imem_addr_o, exp_req);
                r = cyc + $urandom_range(lat_max, lat_min);
                if (r <= last_rdy) r = last_rdy + 1;
                last_rdy = r;
                pend.push_back('{imem_addr_o, r});
                exp_req = exp_req + 32'd4;
                if (first_xfer < 0) first_xfer = int'(cyc);
            end
            if (imem_rvalid_i) begin
                void'(pend.pop_front());
                n_rvalid++;
                if (stale_left > 0) stale_left--;
            end
            if (redirect_i) begin
                exp_pc     = redirect_pc_i;
                exp_req    = redirect_pc_i;
                stale_left = pend.size();
                chk_flush  = 1;
            end
            chk("outstanding_cap", {31'b0, (pend.size() <= DEPTH)}, 32'h1);
            prev_wait = imem_req_o && !imem_gnt_i && !redirect_i;
            prev_addr = imem_addr_o;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic wait_first(input int unsigned bound);
        for (int unsigned k = 0; k < bound && want_first; k++) step();
        chk("first_timeout", {31'b0, want_first}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        // 1: 1-cycle memory, free-running stream from reset
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        first_xfer = -1; first_valid = -1; n_consumed = 0;
        repeat (20) step();
        chk("t1_valid_delay", 32'(first_valid - first_xfer), 32'd2);
        chk("t1_stream_count", {31'b0, (n_consumed >= 15)}, 32'h1);

        // 2: stall fills the queue, then release drains it in order
        stall_i = 1'b1;
        do_reset();
        n_rvalid = 0;
        repeat (10) step();
        chk("t2_buffered", n_rvalid, DEPTH);
        chk("t2_req_low", {31'b0, imem_req_o}, 32'h0);
        chk("t2_head_valid", {31'b0, inst_valid_o}, 32'h1);
        chk("t2_head_pc", pc_o, 32'h0);
        stall_i = 1'b0;
        gnt_pct = 0;
        n_consumed = 0;
        repeat (4) step();
        chk("t2_delivered", n_consumed, 32'd4);
        chk("t2_empty", {31'b0, inst_valid_o}, 32'h0);
        gnt_pct = 100;

        // 3: 3-cycle memory, redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int k = 0; k < 20 && pend.size() != 2; k++) step();
        gnt_pct = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40; want_first = 1;
        step();
        redirect_i = 1'b0; gnt_pct = 100;
        chk("t3_stale", stale_left, 32'd2);
        wait_first(40);
        chk("t3_first_pc", first_pc, 32'h40);

        // 4: redirect, grant and rvalid in the same cycle
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) step();
        triple_hit = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'h100; want_first = 1;
        step();
        redirect_i = 1'b0;
        chk("t4_triple", {31'b0, triple_hit}, 32'h1);
        wait_first(40);
        chk("t4_first_pc", first_pc, 32'h100);

        // 5: one-cycle reset pulse mid-stream
        repeat (8) step();
        rst_ni = 1'b0; want_first = 1;
        step();
        rst_ni = 1'b1;
        chk("t5_req", {31'b0, imem_req_o}, 32'h0);
        chk("t5_addr", imem_addr_o, RESET_PC);
        chk("t5_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("t5_inst", inst_o, 32'h0);
        chk("t5_pc", pc_o, 32'h0);
        chk("t5_pc4", pc4_o, 32'h0);
        wait_first(40);
        chk("t5_first_pc", first_pc, RESET_PC);

        // 6: PC wrap at the top of the address space
        saw_wrap = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; want_first = 1;
        step();
        redirect_i = 1'b0;
        wait_first(40);
        repeat (5) step();
        chk("t6_first_pc", first_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_seen", {31'b0, saw_wrap}, 32'h1);

        // Random traffic: variable latency/grant, stalls, redirects, rare resets
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        n_consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            stall_i       = ($urandom_range(99) < 30);
            redirect_i    = ($urandom_range(99) < 4);
            redirect_pc_i = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            rst_ni        = !($urandom_range(999) < 3);
            if (!rst_ni) redirect_i = 1'b0;
            step();
        end
        rst_ni = 1'b1; redirect_i = 1'b0; stall_i = 1'b0;
        chk("rand_progress", {31'b0, (n_consumed > 100)}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
